// File: rtl/text_vram_scheduler.sv
// text_vram_scheduler: shares a single-port text VRAM between per-cell display fetches and host writes,
// and tracks text row, glyph scan line and blink phase for the glyph/attribute pipeline.
module text_vram_scheduler #(
    parameter int COLS         = 80,
    parameter int ROWS         = 25,
    parameter int CELL_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int ADDR_W       = 11,
    parameter int BLINK_FRAMES = 16
) (
    input  logic                      clk_pixel,
    input  logic                      reset_n,
    input  logic                      frame_start,
    input  logic                      line_start,
    input  logic                      line_end,
    input  logic                      host_valid,
    output logic                      host_ready,
    input  logic [ADDR_W-1:0]         host_addr,
    input  logic [15:0]               host_data,
    output logic [ADDR_W-1:0]         vram_addr,
    output logic                      vram_we,
    output logic [15:0]               vram_wdata,
    input  logic [15:0]               vram_rdata,
    output logic [7:0]                cell_char,
    output logic [7:0]                cell_attr,
    output logic                      cell_valid,
    output logic [$clog2(CHAR_H)-1:0] glyph_row,
    output logic                      blink_phase
);
    localparam int PW    = $clog2(CELL_W);
    localparam int CW    = $clog2(COLS + 1);
    localparam int RW    = $clog2(ROWS + 1);
    localparam int GW    = $clog2(CHAR_H);
    localparam int FW    = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
    localparam int CELLS = COLS * ROWS;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CELL_W - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_END    = RW'(ROWS);
    localparam logic [GW-1:0] GLYPH_LAST = GW'(CHAR_H - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

    logic [PW-1:0]     phase;
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [FW-1:0]     frame_cnt;
    logic              active, fetch_q;
    logic [15:0]       cell_q;
    logic              disp, host_slot, host_wr;
    logic [ADDR_W-1:0] fetch_addr;

    // Host slot is gated by reset_n so a write in flight is dropped the moment reset asserts.
    always_comb begin
        disp       = active && phase == '0;
        host_slot  = reset_n && !disp;
        host_wr    = host_valid && host_slot;
        fetch_addr = ADDR_W'(32'(row) * COLS + 32'(col));
        host_ready = host_slot;
        vram_we    = host_wr && int'(host_addr) < CELLS;
        vram_addr  = disp ? fetch_addr : host_wr ? host_addr : '0;
        vram_wdata = host_wr ? host_data : '0;
        cell_valid = fetch_q;
        {cell_attr, cell_char} = fetch_q ? vram_rdata : cell_q;
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            phase       <= '0;
            col         <= '0;
            row         <= '0;
            glyph_row   <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            active      <= 1'b0;
            fetch_q     <= 1'b0;
            cell_q      <= '0;
        end else begin
            fetch_q <= disp;
            if (fetch_q) cell_q <= vram_rdata;
            if (frame_start) begin
                row       <= '0;
                glyph_row <= '0;
                active    <= 1'b0;
                frame_cnt <= frame_cnt == FRAME_LAST ? '0 : frame_cnt + 1'b1;
                if (frame_cnt == FRAME_LAST) blink_phase <= ~blink_phase;
            end else begin
                if (line_end) begin
                    glyph_row <= glyph_row == GLYPH_LAST ? '0 : glyph_row + 1'b1;
                    if (glyph_row == GLYPH_LAST && row != ROW_END) row <= row + 1'b1;
                end
                if (line_start) begin
                    phase  <= '0;
                    col    <= '0;
                    active <= row != ROW_END;
                end else if (active) begin
                    phase <= phase == PHASE_LAST ? '0 : phase + 1'b1;
                    if (phase == PHASE_LAST) begin
                        col <= col + 1'b1;
                        if (col == COL_LAST) active <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_text_vram_scheduler.sv
// tb_text_vram_scheduler: table vectors, directed corner sequences and randomized traffic
// against a cycle-offset reference model with a shadow copy of VRAM.
module tb_text_vram_scheduler;
    localparam int COLS = 80, ROWS = 25, CELL_W = 8, CHAR_H = 16, ADDR_W = 11, BF = 16;
    localparam int CELLS = COLS * ROWS;

    logic              clk_pixel = 0, reset_n = 0;
    logic              frame_start = 0, line_start = 0, line_end = 0, host_valid = 0;
    logic [ADDR_W-1:0] host_addr = '0;
    logic [15:0]       host_data = '0;
    logic              host_ready, vram_we, cell_valid, blink_phase;
    logic [ADDR_W-1:0] vram_addr;
    logic [15:0]       vram_wdata;
    logic [15:0]       vram_rdata = '0;
    logic [7:0]        cell_char, cell_attr;
    logic [3:0]        glyph_row;

    int nchk = 0, nerr = 0;
    bit chk = 0;

    text_vram_scheduler #(.COLS(COLS), .ROWS(ROWS), .CELL_W(CELL_W), .CHAR_H(CHAR_H),
                          .ADDR_W(ADDR_W), .BLINK_FRAMES(BF)) dut (
        .clk_pixel(clk_pixel), .reset_n(reset_n), .frame_start(frame_start),
        .line_start(line_start), .line_end(line_end), .host_valid(host_valid),
        .host_ready(host_ready), .host_addr(host_addr), .host_data(host_data),
        .vram_addr(vram_addr), .vram_we(vram_we), .vram_wdata(vram_wdata),
        .vram_rdata(vram_rdata), .cell_char(cell_char), .cell_attr(cell_attr),
        .cell_valid(cell_valid), .glyph_row(glyph_row), .blink_phase(blink_phase));

    always #5 clk_pixel = ~clk_pixel;

    // Single-port VRAM with one cycle read latency.
    bit [15:0] mem [2**ADDR_W];
    always @(posedge clk_pixel) begin
        if (vram_we) mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_pixel);
        #1;
    endtask

    // Reference model: position in the line is a cycle offset k since line_start,
    // row/glyph come from the count of line_end pulses since frame_start.
    int k = 0, lines = 0, frames = 0, m_row, m_faddr;
    bit fv = 0, pdisp = 0, m_disp, m_ready, m_hw, m_we;
    bit [15:0] dq = 0;
    bit [15:0] shadow [2**ADDR_W];
    logic [ADDR_W-1:0] m_addr;
    logic [15:0] m_wdata;

    always_comb begin
        m_row   = lines / CHAR_H > ROWS ? ROWS : lines / CHAR_H;
        m_disp  = fv && k % CELL_W == 0;
        m_faddr = m_row * COLS + k / CELL_W;
        m_ready = reset_n === 1'b1 && !m_disp;
        m_hw    = host_valid && m_ready;
        m_we    = m_hw && int'(host_addr) < CELLS;
        m_addr  = m_disp ? ADDR_W'(m_faddr) : m_hw ? host_addr : '0;
        m_wdata = m_hw ? host_data : '0;
    end

    always @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            k <= 0; fv <= 0; lines <= 0; frames <= 0; pdisp <= 0; dq <= 0;
        end else begin
            pdisp <= m_disp;
            if (m_disp) dq <= shadow[m_faddr];
            if (m_we) shadow[host_addr] <= host_data;
            if (frame_start) begin
                lines <= 0; frames <= frames + 1; fv <= 0;
            end else begin
                if (line_end) lines <= lines + 1;
                if (line_start) begin
                    k <= 0; fv <= m_row < ROWS;
                end else if (fv) begin
                    k <= k + 1;
                    if (k + 1 == COLS * CELL_W) fv <= 0;
                end
            end
        end
    end

    always @(negedge clk_pixel)
        if (chk)
            check("cycle", {host_ready, vram_we, vram_addr, vram_wdata, cell_char, cell_attr,
                            cell_valid, glyph_row, blink_phase},
                           {m_ready, m_we, m_addr, m_wdata, dq[7:0], dq[15:8], pdisp,
                            4'(lines % CHAR_H), 1'((frames / BF) % 2)});

    typedef struct {
        logic        hv;
        logic [10:0] ha;
        logic [15:0] hd;
        logic        er;
        logic        ew;
        logic [10:0] ea;
        logic [15:0] ed;
    } vec_t;
    vec_t vt [7];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int low, wes;
        vt[0] = '{1'b1, 11'd0,    16'h1E41, 1'b1, 1'b1, 11'd0,    16'h1E41};
        vt[1] = '{1'b1, 11'd1999, 16'hBEEF, 1'b1, 1'b1, 11'd1999, 16'hBEEF};
        vt[2] = '{1'b1, 11'd2000, 16'h1234, 1'b1, 1'b0, 11'd2000, 16'h1234};
        vt[3] = '{1'b1, 11'd2047, 16'h5555, 1'b1, 1'b0, 11'd2047, 16'h5555};
        vt[4] = '{1'b0, 11'd5,    16'h7777, 1'b1, 1'b0, 11'd0,    16'h0000};
        vt[5] = '{1'b1, 11'd80,   16'h0A42, 1'b1, 1'b1, 11'd80,   16'h0A42};
        vt[6] = '{1'b1, 11'd81,   16'h0C43, 1'b1, 1'b1, 11'd81,   16'h0C43};

        step;
        chk = 1;
        step;
        #2 check("reset_outputs", {host_ready, vram_we, vram_addr, vram_wdata, cell_char,
                 cell_attr, cell_valid, glyph_row, blink_phase}, '0);
        step;
        reset_n = 1;
        step;

        for (int i = 0; i < 7; i++) begin
            host_valid = vt[i].hv; host_addr = vt[i].ha; host_data = vt[i].hd;
            #2 check("host_vec", {host_ready, vram_we, vram_addr, vram_wdata},
                     {vt[i].er, vt[i].ew, vt[i].ea, vt[i].ed});
            step;
        end
        host_valid = 0;

        frame_start = 1; step; frame_start = 0;
        line_start = 1; step; line_start = 0;
        #2 check("first_fetch", {host_ready, vram_we, vram_addr}, {1'b0, 1'b0, 11'd0});
        step;
        #2 check("first_cell", {cell_valid, cell_char, cell_attr}, {1'b1, 8'h41, 8'h1E});

        repeat (20) step;
        line_start = 1; step; line_start = 0;
        #2 check("restart_col0", {host_ready, vram_addr}, {1'b0, 11'd0});
        low = 0; wes = 0;
        for (int i = 0; i < COLS * CELL_W; i++) begin
            host_valid = 1;
            host_addr = ADDR_W'($urandom_range(CELLS - 1, 0));
            host_data = 16'($urandom);
            #1;
            if (!host_ready) low++;
            if (vram_we) wes++;
            step;
        end
        host_valid = 0;
        check("display_slots", low, COLS);
        check("host_writes", wes, COLS * (CELL_W - 1));
        #2 check("idle_ready", host_ready, 1);

        frame_start = 1; step; frame_start = 0;
        line_end = 1; repeat (15) step; line_end = 0;
        #2 check("glyph_15", glyph_row, 15);
        line_end = 1; step; line_end = 0;
        #2 check("glyph_wrap", glyph_row, 0);
        line_start = 1; step; line_start = 0;
        #1 check("row1_fetch", {host_ready, vram_addr}, {1'b0, 11'd80});

        line_end = 1; repeat (3) step; line_end = 0;
        frame_start = 1; line_end = 1; step; frame_start = 0; line_end = 0;
        #2 check("frame_beats_line_end", glyph_row, 0);

        frame_start = 1; step; frame_start = 0;
        line_end = 1; repeat (CHAR_H * ROWS + 20) step; line_end = 0;
        line_start = 1; step; line_start = 0;
        low = 0;
        repeat (24) begin
            #2 if (!host_ready) low++;
            step;
        end
        check("row_saturated_no_fetch", low, 0);

        frame_start = 1; step; frame_start = 0;
        line_end = 1; repeat (3) step; line_end = 0;
        line_start = 1; step; line_start = 0;
        host_valid = 1; host_addr = 11'd100; host_data = 16'($urandom);
        step;
        #1 check("pre_reset", {cell_valid, host_ready, vram_we}, 3'b111);
        reset_n = 0;
        #1 check("reset_mid_fetch", {vram_we, cell_valid, host_ready, glyph_row}, '0);
        host_valid = 0;
        step; step;
        reset_n = 1;
        step;

        for (int i = 1; i <= 32; i++) begin
            frame_start = 1; step; frame_start = 0;
            #2 if (i == 15 || i == 16 || i == 31 || i == 32)
                check("blink", blink_phase, (i == 16 || i == 31) ? 1 : 0);
            step;
        end

        for (int i = 0; i < 4000; i++) begin
            frame_start = $urandom_range(599, 0) == 0;
            line_start  = $urandom_range(149, 0) == 0;
            line_end    = $urandom_range(29, 0) == 0;
            host_valid  = 1'($urandom_range(1, 0));
            host_addr   = ADDR_W'($urandom_range(2047, 0));
            host_data   = 16'($urandom);
            step;
        end
        frame_start = 0; line_start = 0; line_end = 0; host_valid = 0;
        step;
        chk = 0;

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
